// File: rtl/seg7_count_display.sv
// Four-digit multiplexed 7-segment display of a 4-bit up/down count: ones, tens, blank, direction glyph.
// Define LZ_BLANK_EN to blank the tens digit when it would show a leading zero.
module seg7_count_display #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int unsigned     CW         = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]   LAST       = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [6:0]      SEG_BLANK  = 7'h7F;
    localparam logic [6:0]      SEG_U      = 7'h41;
    localparam logic [6:0]      SEG_D      = 7'h21;

    typedef enum logic {ST_BLANK, ST_ON} state_t;
    typedef enum logic {DIR_DOWN, DIR_UP} dir_t;

    logic [3:0]    s1, s2, s3;
    logic [3:0]    disp_val;
    dir_t          dir;
    logic          tens;
    logic [3:0]    ones;
    logic [6:0]    glyph;
    logic [CW-1:0] refresh_cnt;
    logic          wrap;
    state_t        state, state_nx;
    logic [1:0]    idx, idx_nx;
    logic [3:0]    an_nx;
    logic [6:0]    seg_nx;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'h40;
            4'd1:    g = 7'h79;
            4'd2:    g = 7'h24;
            4'd3:    g = 7'h30;
            4'd4:    g = 7'h19;
            4'd5:    g = 7'h12;
            4'd6:    g = 7'h02;
            4'd7:    g = 7'h78;
            4'd8:    g = 7'h00;
            4'd9:    g = 7'h10;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // A value is accepted only once two consecutive samples agree, which rejects single-cycle glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1       <= '0;
            s2       <= '0;
            s3       <= '0;
            disp_val <= '0;
            dir      <= DIR_UP;
        end else begin
            s1 <= count;
            s2 <= s1;
            s3 <= s2;
            if (s2 == s3 && s2 != disp_val) begin
                disp_val <= s2;
                dir      <= (s2 > disp_val) ? DIR_UP : DIR_DOWN;
            end
        end
    end

    always_comb begin
        tens = (disp_val >= 4'd10);
        ones = disp_val - (tens ? 4'd10 : 4'd0);
    end

    always_comb begin
        glyph = SEG_BLANK;
        case (idx)
            2'd0: glyph = digit_glyph(ones);
`ifdef LZ_BLANK_EN
            2'd1: glyph = tens ? digit_glyph(4'd1) : SEG_BLANK;
`else
            2'd1: glyph = digit_glyph({3'b000, tens});
`endif
            2'd2: glyph = SEG_BLANK;
            2'd3: glyph = (dir == DIR_UP) ? SEG_U : SEG_D;
            default: glyph = SEG_BLANK;
        endcase
    end

    assign wrap = (refresh_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
        end else if (wrap) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BLANK;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            ST_BLANK: if (refresh_cnt == BLANK_LAST) state_nx = ST_ON;
            ST_ON: begin
                if (wrap) begin
                    state_nx = ST_BLANK;
                    idx_nx   = idx + 2'd1;
                end
            end
            default: state_nx = ST_BLANK;
        endcase
    end

    // Outputs follow the next state so anodes and segments switch on the same edge as the FSM;
    // the glyph is captured only on slot entry and held for the rest of the slot.
    always_comb begin
        an_nx  = an;
        seg_nx = seg;
        if (state_nx == ST_BLANK) begin
            an_nx  = '1;
            seg_nx = SEG_BLANK;
        end else if (state == ST_BLANK) begin
            an_nx  = ~(4'b0001 << idx);
            seg_nx = glyph;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_nx;
            seg <= seg_nx;
            dp  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_count_display.sv
// Scoreboard bench for seg7_count_display: expected slots are queued from a count-history model, a negedge monitor checks them.
module tb_seg7_count_display;

    localparam int unsigned DIV  = 8;
    localparam int unsigned BLK  = 2;
    localparam int unsigned HMAX = 8192;

    logic       clk;
    logic       rst;
    logic [3:0] count;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int unsigned edge_n;
        logic [3:0]  an;
        logic [6:0]  seg;
    } exp_t;

    exp_t        q[$];
    int unsigned ecnt = 0;
    logic [3:0]  samp [HMAX];
    logic [6:0]  digit_seg [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                    7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seg7_count_display #(
        .REFRESH_DIV (DIV),
        .BLANK_CYCLES(BLK)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .count(count),
        .seg  (seg),
        .dp   (dp),
        .an   (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Shown value: the latest value seen on two consecutive clk samples, visible from the 4th edge after it appeared.
    function automatic void model(input int unsigned e, output int val, output bit up);
        val = 0;
        up  = 1'b1;
        for (int unsigned k = 1; k + 3 <= e; k++) begin
            if (samp[k] == samp[k+1] && int'(samp[k]) != val) begin
                up  = int'(samp[k]) > val;
                val = int'(samp[k]);
            end
        end
    endfunction

    function automatic logic [6:0] exp_glyph(input int d_idx, input int val, input bit up);
        logic [6:0] g;
        int t;
        t = val / 10;
        case (d_idx)
            0: g = digit_seg[val % 10];
`ifdef LZ_BLANK_EN
            1: g = (t == 0) ? 7'h7F : digit_seg[t];
`else
            1: g = digit_seg[t];
`endif
            2: g = 7'h7F;
            default: g = up ? 7'h41 : 7'h21;
        endcase
        return g;
    endfunction

    // Every slot should go live at edge n*DIV+BLK after reset release on digit (n mod 4).
    always @(posedge clk) begin
        if (rst) begin
            ecnt = 0;
        end else begin
            int   v;
            bit   up;
            int   d;
            exp_t x;
            ecnt = ecnt + 1;
            if (ecnt < HMAX) samp[ecnt] = count;
            if (ecnt % DIV == BLK) begin
                model(ecnt - 1, v, up);
                d        = int'((ecnt / DIV) % 4);
                x.edge_n = ecnt;
                x.an     = ~(4'b0001 << d);
                x.seg    = exp_glyph(d, v, up);
                q.push_back(x);
            end
        end
    end

    logic [3:0] prev_an  = 4'hF;
    logic [6:0] prev_seg = 7'h7F;

    always @(negedge clk) begin
        if (rst) begin
            prev_an = 4'hF;
        end else begin
            if (an != 4'hF && an != prev_an) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL slot_unexpected: got an=%b at edge %0d, expected no active slot", an, ecnt);
                end else begin
                    exp_t h;
                    h = q.pop_front();
                    chk("slot_edge", int'(ecnt), int'(h.edge_n));
                    chk("slot_an", int'(an), int'(h.an));
                    chk("slot_seg", int'(seg), int'(h.seg));
                    chk("slot_dp", int'(dp), 1);
                end
            end else if (an != 4'hF) begin
                chk("seg_hold", int'(seg), int'(prev_seg));
            end else begin
                chk("blank_seg", int'(seg), 'h7F);
                if (prev_an != 4'hF) chk("slot_end_phase", int'(ecnt % DIV), 0);
            end
            prev_an  = an;
            prev_seg = seg;
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_hold(input int v, input int n);
        count = 4'(v);
        hold(n);
    endtask

    initial begin
        rst   = 1'b1;
        count = 4'd0;
        hold(3);
        #1;
        chk("reset_an", int'(an), 'hF);
        chk("reset_seg", int'(seg), 'h7F);
        chk("reset_dp", int'(dp), 1);
        @(negedge clk);
        rst = 1'b0;

        set_hold(0, 8 * DIV);
        set_hold(9, 40);
        set_hold(10, 9 * DIV);
        set_hold(15, 40);
        set_hold(14, 9 * DIV);
        set_hold(3, 9 * DIV);
        set_hold(5, 40);
        set_hold(6, 1);
        set_hold(5, 9 * DIV);

        for (int i = 0; i < 100 && an == 4'hF; i++) @(negedge clk);
        chk("reached_on_phase", int'(an != 4'hF), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_an", int'(an), 'hF);
        chk("async_rst_seg", int'(seg), 'h7F);
        chk("async_rst_dp", int'(dp), 1);
        chk("queue_at_reset", q.size(), 0);
        q.delete();
        hold(2);
        count = 4'd7;
        rst   = 1'b0;
        hold(5 * DIV);

        repeat (25) begin
            set_hold(int'($urandom_range(0, 15)), int'($urandom_range(1, 30)));
        end
        hold(10 * DIV);
        #2;
        chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_count_display.md
SEG7_COUNT_DISPLAY -- requirements
Module: seg7_count_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit slot (ON phase plus blank phase), legal range 8..2^20.
REQ-002 SHALL have parameter BLANK_CYCLES, default 16, clk cycles per slot with all anodes off, legal range 1..REFRESH_DIV-2.
REQ-003 SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port count, input, 4 bits: up/down counter value, asynchronous to clk (divided-clock domain).
REQ-006 SHALL have port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active low, registered.
REQ-007 SHALL have port dp, output, 1 bit: decimal point, active low, registered.
REQ-008 SHALL have port an, output, 4 bits: digit anodes, active low, one-hot-low or all high, registered.

Function
REQ-009 SHALL pass count through three flops (s1, s2, s3) clocked by clk.
REQ-010 SHALL load disp_val from s2 only when s2 == s3 and s2 != disp_val; latency: disp_val updates on the 4th rising clk after count becomes stable.
REQ-011 SHALL, on each disp_val load, set dir = UP if new > old and dir = DOWN if new < old; dir is otherwise held.
REQ-012 SHALL derive tens = (disp_val >= 10) and ones = disp_val - 10*tens, using 4-bit unsigned arithmetic only.
REQ-013 SHALL map digits as follows: an[0] = ones, an[1] = tens, an[2] = blank, an[3] = 'U' when dir = UP or 'd' when dir = DOWN.
REQ-014 SHALL encode glyphs as follows: 0-9 standard 7-segment; 'U' = b,c,d,e,f; 'd' = b,c,d,e,g; blank = all segments off.
REQ-015 SHALL run a refresh counter from 0 to REFRESH_DIV-1 and wrap to 0; each wrap ends a digit slot.
REQ-016 SHALL run a scan FSM with states BLANK and ON, plus a 2-bit digit index idx.
REQ-017 SHALL behave in BLANK as follows: an = 4'b1111, seg = 7'h7F; move to ON when refresh counter == BLANK_CYCLES-1.
REQ-018 SHALL behave in ON as follows: an[idx] = 0, seg = glyph(idx); at refresh wrap, go to BLANK and set idx = idx+1 mod 4 (3 -> 0).
REQ-019 SHALL latch the glyph for the slot on entry to ON; a disp_val change mid-slot appears in the next slot of that digit.
REQ-020 SHALL hold dp = 1 at all times.
REQ-021 SHALL register all outputs; an and seg change on the same clk edge.

Reset
REQ-022 SHALL, while rst = 1, force the following values: an = 4'b1111, seg = 7'h7F, dp = 1, s1/s2/s3 = 0, disp_val = 0, dir = UP, refresh counter = 0, FSM = BLANK, idx = 0.
REQ-023 SHALL, on assertion of rst mid-slot, blank the outputs immediately without waiting for clk; after rst deasserts, scanning restarts at digit 0 with a full blank phase.

Configuration
REQ-024 SHALL, with LZ_BLANK_EN defined, show the tens digit blank when tens = 0.
REQ-025 SHALL, with LZ_BLANK_EN undefined, always show the tens digit, including '0'.

Verification
REQ-026 SHALL cover: REFRESH_DIV=8, BLANK_CYCLES=2, count=0 -> an sequence 1110,1101,1011,0111, each low for 6 clk with 2 clk 1111 between; seg = 7'h40 ('0') on an[0], 7'h41 ('U') on an[3].
REQ-027 SHALL cover: count steps 9 -> 10 -> ones digit seg = 7'h40, tens digit seg = 7'h79 ('1'), digit 3 stays 'U'.
REQ-028 SHALL cover: count 15 -> 14 -> dir = DOWN, digit 3 seg = 7'h21 ('d'), ones digit seg = 7'h19 ('4').
REQ-029 SHALL cover: count glitches to 6 for one clk between stable 5 values -> disp_val remains 5, dir unchanged.
REQ-030 SHALL cover: count = 3, compiled with and without LZ_BLANK_EN -> tens digit seg = 7'h7F with the macro, 7'h40 without.
REQ-031 SHALL cover: rst pulsed asynchronously during an ON phase -> an = 1111 before the next clk edge; after release, first active anode is an[0] after 2 blank clk.
